argmax_classifier: RTL and testbench
====================================

Name: argmax_classifier

Overview:
- Consumer of the output-layer activation bus.
- On the layer's completion pulse it snapshots the OL_neurons post-ReLU activations and scans them sequentially, one per clock.
- Reports the index of the largest activation (the recognised digit), its value, and a one-cycle done pulse to the display/control logic.

Parameters:
- OL_neurons, 10: number of activations (output neurons) to scan; must be ≥ 2.
- WIDTH, 8: base weight width; each activation is 4*WIDTH bits signed (ACT_W).
- IDX_W, $clog2(OL_neurons) (4 at default): width of the reported index.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- argmax_go  input  1  start pulse; driven by the output layer's done pulse.
- argmax_in  input  ACT_W*OL_neurons  activation bus; element i at bits [i*ACT_W +: ACT_W], element 0 in the LSBs, signed two's complement.
- digit_out  output  IDX_W  index of the maximum element.
- max_value  output  ACT_W  signed value of the maximum element.
- argmax_done  output  1  one-cycle result-valid pulse.
- busy  output  1  high while a scan is in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; digit_out=0, max_value=0, argmax_done=0, busy=0; snapshot, index counter and best registers cleared.
- State machine IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - busy=0.
  - argmax_go sampled high at edge k: snapshot all of argmax_in, best_val=elem0, best_idx=0, idx=1; go to SCAN.
- SCAN:
  - busy=1.
  - Each edge compares elem[idx] (signed) against best_val.
  - Strictly greater: replace best_val/best_idx. Ties keep the lower index.
  - idx increments; after the idx=OL_neurons-1 compare, go to DONE.
  - SCAN lasts OL_neurons-1 cycles.
- DONE:
  - busy=1.
  - Next edge loads digit_out=best_idx, max_value=best_val, sets argmax_done=1 for exactly one cycle, and returns to IDLE (busy=0).
- Latency: go sampled at edge k -> argmax_done high after edge k+OL_neurons (10 at default).
- digit_out/max_value hold their values until the next completed scan; they are not cleared at start.
- argmax_go while busy=1: ignored; no queueing, no restart.
- argmax_go in the cycle argmax_done=1: the FSM is already in IDLE, so the go is accepted and a new scan starts.
- argmax_in changes during a scan have no effect (snapshot).
- All-equal input (including all zero): digit_out=0.
- Negative values are compared signed, even though ReLU inputs are normally ≥ 0.
- Reset asserted mid-scan: immediate abort to the reset values; no done pulse; outputs from the previous result are lost.
- Index counter width: IDX_W; it never wraps because the counter stops at OL_neurons-1.

Optional Feature:
- Macro: ARGMAX_TIE_DETECT_EN.
- Defined:
  - Adds output port tie_flag (1 bit), reset 0.
  - An internal tie bit clears at snapshot, sets when elem[idx]==best_val, and clears when elem[idx]>best_val.
  - tie_flag is loaded alongside digit_out in DONE.
  - tie_flag=1 means another element equals the reported maximum.
- Not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package nn_pkg:
  - constants OL_neurons, WIDTH, ACT_W=4*WIDTH, IDX_W;
  - state enum typedef {IDLE, SCAN, DONE};
  - activation typedef logic signed [ACT_W-1:0].
- One natural sub-module, argmax_cmp:
  - purely combinational signed compare;
  - inputs: candidate, best_val, candidate idx, best_idx;
  - outputs: take_new, and equal when ARGMAX_TIE_DETECT_EN is defined.
  - Reusable by the other layers' debug logic.

Test Plan:
- Elements {0,5,3,9,1,9,2,0,4,7}, pulse go -> done exactly 10 cycles later, digit_out=3, max_value=9, busy high for 10 cycles; with TIE_DETECT, tie_flag=1.
- All elements 0 -> digit_out=0, max_value=0; tie_flag=1 if enabled.
- Maximum only at element 9 (value 0x7FFFFFFF, others 1) -> digit_out=9, max_value=0x7FFFFFFF; with mixed negatives {-5,-2,-9,...} the signed max is chosen.
- Pulse go, then change argmax_in and pulse go again at cycles 3 and 5 -> result reflects the first snapshot only; a single done pulse.
- Assert reset at cycle 4 of a scan -> outputs 0 immediately, no done; a new go after release produces the correct result after 10 cycles.
- go in the same cycle argmax_done=1 -> a second scan starts; second done 10 cycles later with the new input's result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the output-layer argmax classifier.
// ARGMAX_TIE_DETECT_EN (optional) is consumed by argmax_cmp and argmax_classifier.
package nn_pkg;

  localparam int OL_neurons = 10;
  localparam int WIDTH      = 8;
  localparam int ACT_W      = 4 * WIDTH;
  localparam int IDX_W      = $clog2(OL_neurons);

  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [1:0]              state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam idx_t LAST_IDX = IDX_W'(OL_neurons - 1);

  // True once the final element has been compared.
  function automatic logic is_last(input idx_t idx);
    return (idx == LAST_IDX);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare used by the argmax scan; ties favour the lower index.
// With ARGMAX_TIE_DETECT_EN defined an equality output is also provided.
module argmax_cmp
  import nn_pkg::*;
(
  input  act_t cand,
  input  act_t best_val,
  input  idx_t cand_idx,
  input  idx_t best_idx,
  output logic take_new
`ifdef ARGMAX_TIE_DETECT_EN
  ,
  output logic equal
`endif
);

  // Replace on strictly greater, or on an equal value held at a higher index.
  always_comb begin
    take_new = 1'b0;
    if (cand > best_val) begin
      take_new = 1'b1;
    end else if ((cand == best_val) && (cand_idx < best_idx)) begin
      take_new = 1'b1;
    end else begin
      take_new = 1'b0;
    end
  end

`ifdef ARGMAX_TIE_DETECT_EN
  assign equal = (cand == best_val);
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Snapshots the output-layer activations and scans them one per clock for the maximum.
// Optional ARGMAX_TIE_DETECT_EN adds tie_flag when another element equals the maximum.
module argmax_classifier
  import nn_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        argmax_go,
  input  logic [ACT_W*OL_neurons-1:0] argmax_in,
  output logic [IDX_W-1:0]            digit_out,
  output logic [ACT_W-1:0]            max_value,
  output logic                        argmax_done,
  output logic                        busy
`ifdef ARGMAX_TIE_DETECT_EN
  ,
  output logic                        tie_flag
`endif
);

  state_t state_r;
  act_t   snap_r [OL_neurons];
  idx_t   idx_r;
  idx_t   best_idx_r;
  act_t   best_val_r;
  act_t   cand_s;
  logic   take_new_s;
`ifdef ARGMAX_TIE_DETECT_EN
  logic   equal_s;
  logic   tie_r;
`endif

  assign cand_s = snap_r[idx_r];

  argmax_cmp u_cmp (
    .cand     (cand_s),
    .best_val (best_val_r),
    .cand_idx (idx_r),
    .best_idx (best_idx_r),
    .take_new (take_new_s)
`ifdef ARGMAX_TIE_DETECT_EN
    ,
    .equal    (equal_s)
`endif
  );

  // Scan FSM, snapshot, running best and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      best_idx_r  <= {IDX_W{1'b0}};
      best_val_r  <= {ACT_W{1'b0}};
      digit_out   <= {IDX_W{1'b0}};
      max_value   <= {ACT_W{1'b0}};
      argmax_done <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < OL_neurons; i++) begin
        snap_r[i] <= {ACT_W{1'b0}};
      end
`ifdef ARGMAX_TIE_DETECT_EN
      tie_r       <= 1'b0;
      tie_flag    <= 1'b0;
`endif
    end else begin
      argmax_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (argmax_go) begin
            for (int i = 0; i < OL_neurons; i++) begin
              snap_r[i] <= argmax_in[i*ACT_W +: ACT_W];
            end
            best_val_r <= argmax_in[ACT_W-1:0];
            best_idx_r <= {IDX_W{1'b0}};
            idx_r      <= IDX_W'(1);
            busy       <= 1'b1;
            state_r    <= SCAN;
`ifdef ARGMAX_TIE_DETECT_EN
            tie_r      <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (take_new_s) begin
            best_val_r <= cand_s;
            best_idx_r <= idx_r;
          end
`ifdef ARGMAX_TIE_DETECT_EN
          // A new maximum invalidates any earlier tie.
          if (take_new_s) begin
            tie_r <= 1'b0;
          end else if (equal_s) begin
            tie_r <= 1'b1;
          end
`endif
          if (is_last(idx_r)) begin
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          digit_out   <= best_idx_r;
          max_value   <= best_val_r;
          argmax_done <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
`ifdef ARGMAX_TIE_DETECT_EN
          tie_flag    <= tie_r;
`endif
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier with hand-computed expectations.
// Tie checks are compiled in when ARGMAX_TIE_DETECT_EN is defined.
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int AW = 32;

  logic            clk;
  logic            reset;
  logic            argmax_go;
  logic [AW*N-1:0] argmax_in;
  logic [3:0]      digit_out;
  logic [AW-1:0]   max_value;
  logic            argmax_done;
  logic            busy;
`ifdef ARGMAX_TIE_DETECT_EN
  logic            tie_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [AW-1:0] elems [N];

  argmax_classifier dut (
    .clk         (clk),
    .reset       (reset),
    .argmax_go   (argmax_go),
    .argmax_in   (argmax_in),
    .digit_out   (digit_out),
    .max_value   (max_value),
    .argmax_done (argmax_done),
    .busy        (busy)
`ifdef ARGMAX_TIE_DETECT_EN
    ,
    .tie_flag    (tie_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int e0, input int e1, input int e2, input int e3, input int e4,
                         input int e5, input int e6, input int e7, input int e8, input int e9);
    elems[0] = e0; elems[1] = e1; elems[2] = e2; elems[3] = e3; elems[4] = e4;
    elems[5] = e5; elems[6] = e6; elems[7] = e7; elems[8] = e8; elems[9] = e9;
    for (int i = 0; i < N; i++) argmax_in[i*AW +: AW] = elems[i];
  endtask

  task automatic pulse_go();
    @(negedge clk);
    argmax_go = 1'b1;
    @(negedge clk);
    argmax_go = 1'b0;
  endtask

  // Starts at the negedge after the go edge; returns at the negedge where done is seen.
  task automatic wait_done(input bit inject, output int lat, output int bcnt);
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 30; n++) begin
      if (inject && (n == 3 || n == 5)) begin
        argmax_go = 1'b1;
        set_vec(100, 200, 300, 400, 500, 600, 700, 800, 900, 1000);
      end else begin
        argmax_go = 1'b0;
      end
      @(negedge clk);
      if (argmax_done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
    argmax_go = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int idx, input int val, input bit tie);
    check_eq({tag, "_digit"}, 32'(digit_out), 32'(idx));
    check_eq({tag, "_max"}, max_value, 32'(val));
`ifdef ARGMAX_TIE_DETECT_EN
    check_eq({tag, "_tie"}, 32'(tie_flag), 32'(tie));
`else
    if (tie) begin end
`endif
  endtask

  task automatic run_scan(input string tag, input int idx, input int val, input bit tie);
    int lat, bcnt;
    pulse_go();
    wait_done(1'b0, lat, bcnt);
    check_eq({tag, "_lat"}, 32'(lat), 32'd10);
    check_eq({tag, "_busy"}, 32'(bcnt), 32'd10);
    expect_result(tag, idx, val, tie);
  endtask

  initial begin
    int lat, bcnt, extra;
    reset     = 1'b0;
    argmax_go = 1'b0;
    argmax_in = '0;
    #1;
    check_eq("rst_digit", 32'(digit_out), 32'd0);
    check_eq("rst_max", max_value, 32'd0);
    check_eq("rst_done", 32'(argmax_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef ARGMAX_TIE_DETECT_EN
    check_eq("rst_tie", 32'(tie_flag), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    set_vec(0, 5, 3, 9, 1, 9, 2, 0, 4, 7);
    run_scan("basic", 3, 9, 1'b1);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(argmax_done), 32'd0);
    check_eq("hold_digit", 32'(digit_out), 32'd3);

    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_scan("zero", 0, 0, 1'b1);

    set_vec(1, 1, 1, 1, 1, 1, 1, 1, 1, 32'h7FFFFFFF);
    run_scan("top9", 9, 32'h7FFFFFFF, 1'b0);

    set_vec(-5, -2, -9, -3, -7, -4, -8, -6, -10, -11);
    run_scan("neg", 1, -2, 1'b0);

    // Gos during the scan and a changed bus must not disturb the first snapshot.
    set_vec(1, 2, 3, 4, 5, 6, 7, 8, 9, 0);
    pulse_go();
    wait_done(1'b1, lat, bcnt);
    check_eq("ign_lat", 32'(lat), 32'd10);
    expect_result("ign", 8, 9, 1'b0);
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (argmax_done) extra++;
    end
    check_eq("ign_single_done", 32'(extra), 32'd0);
    check_eq("ign_idle", 32'(busy), 32'd0);

    // Reset in the middle of a scan.
    set_vec(50, 60, 70, 80, 90, 10, 20, 30, 40, 55);
    pulse_go();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_digit", 32'(digit_out), 32'd0);
    check_eq("mid_rst_max", max_value, 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (argmax_done) extra++;
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (argmax_done) extra++;
    end
    check_eq("mid_rst_no_done", 32'(extra), 32'd0);
    set_vec(7, 1, 2, 3, 4, 5, 6, 7, 0, 0);
    run_scan("after_rst", 0, 7, 1'b1);

    // Go in the very cycle done is high starts a second scan.
    @(negedge clk);
    set_vec(2, 8, 1, 1, 1, 1, 1, 1, 1, 1);
    pulse_go();
    wait_done(1'b0, lat, bcnt);
    check_eq("b2b_a_lat", 32'(lat), 32'd10);
    expect_result("b2b_a", 1, 8, 1'b0);
    set_vec(-1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    argmax_go = 1'b1;
    @(negedge clk);
    argmax_go = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    wait_done(1'b0, lat, bcnt);
    check_eq("b2b_b_lat", 32'(lat), 32'd10);
    expect_result("b2b_b", 0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
